// File: rtl/debug_pkg.sv
// Shared types for the debug run controller: command opcodes, controller states,
// halt causes and the step-counter width.
package debug_pkg;
    localparam int STEP_W = 16;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_HALT       = 3'd1,
        OP_RESUME     = 3'd2,
        OP_STEP       = 3'd3,
        OP_RESET_CORE = 3'd4,
        OP_SET_BP     = 3'd5,
        OP_CLR_BP     = 3'd6,
        OP_INVALID    = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HALTED     = 2'd1,
        ST_STEPPING   = 2'd2,
        ST_CORE_RESET = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE  = 2'd0,
        HC_CMD   = 2'd1,
        HC_BREAK = 2'd2,
        HC_STEP  = 2'd3
    } halt_cause_e;
endpackage

// File: rtl/debug_bp_unit.sv
// Single hardware breakpoint: address register, PC comparator and the one-shot
// skip that lets the core step off a breakpoint it was halted on.
module debug_bp_unit
    import debug_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_set_bp,
    input  logic              i_clr_bp,
    input  logic [ADDR_W-1:0] i_bp_addr,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_active,
    input  logic              i_leave_halt,
    output logic              o_bp_hit
);
    logic              r_bp_en;
    logic [ADDR_W-1:0] r_bp_addr;
    logic              r_skip_bp;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bp_en   <= 1'b0;
            r_bp_addr <= '0;
            r_skip_bp <= 1'b0;
        end else begin
            if (i_set_bp) begin
                r_bp_en   <= 1'b1;
                r_bp_addr <= i_bp_addr;
            end else if (i_clr_bp) begin
                r_bp_en <= 1'b0;
            end
            // Skip covers only the first active cycle after leaving HALTED.
            if (i_leave_halt)
                r_skip_bp <= 1'b1;
            else if (i_active)
                r_skip_bp <= 1'b0;
        end
    end

    assign o_bp_hit = r_bp_en && (i_pc == r_bp_addr) && !r_skip_bp && i_active;
endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run controller: run/halt/step/core-reset sequencing of a core clock
// enable, with breakpoint halting and an enabled-cycle counter.
module debug_run_ctrl
    import debug_pkg::*;
#(
    parameter int RESET_PULSE_CYCLES = 4,
    parameter bit START_HALTED       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    output logic        cmd_ready,
    input  logic [31:0] pc,
    output logic        core_clk_en,
    output logic        core_reset,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] cycle_count,
    output logic        cmd_err
);
    localparam state_e     RESET_STATE = START_HALTED ? ST_HALTED : ST_RUN;
    localparam logic [7:0] PULSE_INIT  = 8'(RESET_PULSE_CYCLES);

    state_e             r_state;
    halt_cause_e        r_halt_cause;
    logic               r_core_reset;
    logic [31:0]        r_cycle_count;
    logic               r_cmd_err;
    logic [STEP_W-1:0]  r_step_cnt;
    logic [7:0]         r_rst_cnt;

    cmd_op_e            w_op;
    logic               w_accept;
    logic               w_active;
    logic               w_leave_halt;
    logic               w_bp_hit;
    logic               w_clk_en;
    logic [STEP_W-1:0]  w_step_load;

    assign w_op         = cmd_op_e'(cmd_op);
    assign cmd_ready    = (r_state != ST_CORE_RESET);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEPPING);
    assign w_leave_halt = w_accept && (r_state == ST_HALTED) &&
                          ((w_op == OP_RESUME) || (w_op == OP_STEP));
    assign w_clk_en     = (w_active || (r_state == ST_CORE_RESET)) && !w_bp_hit;
    assign w_step_load  = (cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_arg[STEP_W-1:0];

    debug_bp_unit u_bp (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_set_bp     (w_accept && (w_op == OP_SET_BP)),
        .i_clr_bp     (w_accept && (w_op == OP_CLR_BP)),
        .i_bp_addr    (cmd_arg),
        .i_pc         (pc),
        .i_active     (w_active),
        .i_leave_halt (w_leave_halt),
        .o_bp_hit     (w_bp_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RESET_STATE;
            r_halt_cause  <= HC_NONE;
            r_core_reset  <= 1'b0;
            r_cycle_count <= '0;
            r_cmd_err     <= 1'b0;
            r_step_cnt    <= '0;
            r_rst_cnt     <= '0;
        end else begin
            r_cmd_err <= w_accept && (w_op == OP_INVALID);
            if (w_clk_en && (r_state != ST_CORE_RESET))
                r_cycle_count <= r_cycle_count + 32'd1;
            if ((r_state == ST_STEPPING) && w_clk_en)
                r_step_cnt <= r_step_cnt - STEP_W'(1);

            if (r_state == ST_CORE_RESET) begin
                r_cycle_count <= '0;
                if (r_rst_cnt <= 8'd1) begin
                    r_core_reset <= 1'b0;
                    r_state      <= ST_HALTED;
                    r_halt_cause <= HC_NONE;
                end else begin
                    r_rst_cnt <= r_rst_cnt - 8'd1;
                end
            end else if (w_accept && (w_op == OP_RESET_CORE)) begin
                r_state       <= ST_CORE_RESET;
                r_core_reset  <= 1'b1;
                r_rst_cnt     <= PULSE_INIT;
                r_cycle_count <= '0;
            // Halt sources in priority order: breakpoint, step completion, command.
            end else if (w_bp_hit) begin
                r_state      <= ST_HALTED;
                r_halt_cause <= HC_BREAK;
            end else if ((r_state == ST_STEPPING) && (r_step_cnt <= STEP_W'(1))) begin
                r_state      <= ST_HALTED;
                r_halt_cause <= HC_STEP;
            end else if (w_accept) begin
                case (w_op)
                    OP_HALT: begin
                        if (w_active) begin
                            r_state      <= ST_HALTED;
                            r_halt_cause <= HC_CMD;
                        end
                    end
                    OP_RESUME: begin
                        if (r_state != ST_RUN) begin
                            r_state      <= ST_RUN;
                            r_halt_cause <= HC_NONE;
                        end
                    end
                    OP_STEP: begin
                        if (r_state == ST_HALTED) begin
                            r_state    <= ST_STEPPING;
                            r_step_cnt <= w_step_load;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign core_clk_en = w_clk_en;
    assign core_reset  = r_core_reset;
    assign halted      = (r_state == ST_HALTED);
    assign halt_cause  = r_halt_cause;
    assign cycle_count = r_cycle_count;
    assign cmd_err     = r_cmd_err;
endmodule
